// File: rtl/rom_byte_streamer_if.sv
// Byte stream carrying one symbol per transfer, tagged with its byte address.
// A transfer happens on a rising clock edge when out_valid and out_ready are both high.
interface rom_byte_streamer_if #(
  parameter int BYTE_W = 8,
  parameter int BADR_W = 10
);
  logic              out_valid;
  logic              out_ready;
  logic [BYTE_W-1:0] out_byte;
  logic [BADR_W-1:0] out_badr;

  modport master (
    output out_valid,
    output out_byte,
    output out_badr,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_byte,
    input  out_badr,
    output out_ready
  );
endinterface

// File: rtl/rom_byte_streamer.sv
// ROM dumper: walks an inclusive, wrapping word-address range and serialises each word
// into address-tagged bytes on a valid/ready stream, LSB-first or MSB-first.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for start; range and byte order latched on start
//   S_FETCH | rom_adr held for ROM_LAT+1 cycles, word captured on last edge
//   S_EMIT  | out_valid high, one byte per transfer, k walks up or down
//   S_DONE  | one-cycle done pulse with busy low, then back to idle
module rom_byte_streamer #(
  parameter int ADDR_W  = 8,
  parameter int WORD_W  = 32,
  parameter int BYTE_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_adr,
  input  logic [ADDR_W-1:0] last_adr,
  input  logic              msb_first,
  output logic [ADDR_W-1:0] rom_adr,
  input  logic [WORD_W-1:0] rom_data,
  output logic              busy,
  output logic              done,
  rom_byte_streamer_if.master strm
);

  localparam int NB     = WORD_W / BYTE_W;
  localparam int KW     = (NB > 1) ? $clog2(NB) : 1;
  localparam int BADR_W = ADDR_W + $clog2(NB);
  localparam int LW     = (ROM_LAT > 0) ? $clog2(ROM_LAT + 1) : 1;

  localparam logic [KW-1:0] K_MAX  = KW'(NB - 1);
  localparam logic [LW-1:0] LAT_LD = LW'(ROM_LAT);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EMIT, S_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] words_left;
  logic [LW-1:0]     fetch_cnt;
  logic [WORD_W-1:0] word;
  logic [KW-1:0]     k;
  logic              msb;

  logic [KW-1:0]     k_first;
  logic [KW-1:0]     k_last;
  logic [KW-1:0]     k_nxt;

  function automatic logic [BYTE_W-1:0] pick(input logic [WORD_W-1:0] w,
                                             input logic [KW-1:0]     idx);
    logic [BYTE_W-1:0] b;
    b = '0;
    for (int i = 0; i < NB; i++) begin
      if (idx == KW'(i)) b = w[i*BYTE_W +: BYTE_W];
    end
    return b;
  endfunction

  // Kept in BADR_W bits so the top-word to word-0 wrap also wraps the byte address.
  function automatic logic [BADR_W-1:0] badr_of(input logic [ADDR_W-1:0] a,
                                                input logic [KW-1:0]     idx);
    logic [BADR_W-1:0] base;
    base = BADR_W'(a) * BADR_W'(NB);
    return base + BADR_W'(idx);
  endfunction

  always_comb begin
    k_first = msb ? K_MAX : '0;
    k_last  = msb ? '0 : K_MAX;
    k_nxt   = msb ? (k - KW'(1)) : (k + KW'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      words_left     <= '0;
      fetch_cnt      <= '0;
      word           <= '0;
      k              <= '0;
      msb            <= 1'b0;
      rom_adr        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      strm.out_valid <= 1'b0;
      strm.out_byte  <= '0;
      strm.out_badr  <= '0;
    end else begin
      done <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        state          <= S_IDLE;
        strm.out_valid <= 1'b0;
        busy           <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              rom_adr    <= first_adr;
              words_left <= last_adr - first_adr;
              msb        <= msb_first;
              fetch_cnt  <= LAT_LD;
              busy       <= 1'b1;
              state      <= S_FETCH;
            end
          end
          S_FETCH: begin
            if (fetch_cnt == '0) begin
              word           <= rom_data;
              k              <= k_first;
              strm.out_byte  <= pick(rom_data, k_first);
              strm.out_badr  <= badr_of(rom_adr, k_first);
              strm.out_valid <= 1'b1;
              state          <= S_EMIT;
            end else begin
              fetch_cnt <= fetch_cnt - LW'(1);
            end
          end
          S_EMIT: begin
            if (strm.out_ready) begin
              if (k == k_last) begin
                strm.out_valid <= 1'b0;
                if (words_left == '0) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_DONE;
                end else begin
                  words_left <= words_left - ADDR_W'(1);
                  rom_adr    <= rom_adr + ADDR_W'(1);
                  fetch_cnt  <= LAT_LD;
                  state      <= S_FETCH;
                end
              end else begin
                k             <= k_nxt;
                strm.out_byte <= pick(word, k_nxt);
                strm.out_badr <= badr_of(rom_adr, k_nxt);
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_byte_streamer.sv
// Bench for rom_byte_streamer: a default 32/8 instance with a 1-cycle ROM and a 16/8
// instance with a 2-cycle ROM, checked against a queue of expected bytes per dump.
module tb_rom_byte_streamer;

  localparam int NB = 4;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  first_adr = '0;
  logic [7:0]  last_adr = '0;
  logic        msb_first = 1'b0;
  logic [7:0]  rom_adr;
  logic [31:0] rom_data = '0;
  logic        busy;
  logic        done;
  logic [31:0] rom1 [256];

  rom_byte_streamer_if #(.BYTE_W(8), .BADR_W(10)) s1 ();

  rom_byte_streamer #(.ADDR_W(8), .WORD_W(32), .BYTE_W(8), .ROM_LAT(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .first_adr(first_adr), .last_adr(last_adr), .msb_first(msb_first),
    .rom_adr(rom_adr), .rom_data(rom_data), .busy(busy), .done(done),
    .strm(s1)
  );

  always @(posedge clk) rom_data <= rom1[rom_adr];

  // 16-bit word, 2-cycle ROM instance
  logic        rst2 = 1'b1;
  logic        start2 = 1'b0;
  logic        abort2 = 1'b0;
  logic [7:0]  fa2 = '0;
  logic [7:0]  la2 = '0;
  logic        msb2 = 1'b0;
  logic [7:0]  rom_adr2;
  logic [15:0] d2a = '0;
  logic [15:0] rom_data2 = '0;
  logic        busy2;
  logic        done2;
  logic [15:0] rom2 [256];

  rom_byte_streamer_if #(.BYTE_W(8), .BADR_W(9)) s2 ();

  rom_byte_streamer #(.ADDR_W(8), .WORD_W(16), .BYTE_W(8), .ROM_LAT(2)) u2 (
    .clk(clk), .rst(rst2), .start(start2), .abort(abort2),
    .first_adr(fa2), .last_adr(la2), .msb_first(msb2),
    .rom_adr(rom_adr2), .rom_data(rom_data2), .busy(busy2), .done(done2),
    .strm(s2)
  );

  always @(posedge clk) begin
    d2a       <= rom2[rom_adr2];
    rom_data2 <= d2a;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One dump on u1. mode 0: ready tied high; mode 1: random ready plus a 3-cycle stall.
  // abort_after >= 0: abort together with that transfer. restart_at >= 0: pulse start mid-EMIT.
  task automatic run_dump(input logic [7:0] fa, input logic [7:0] la, input logic msb,
                          input int mode, input int abort_after, input int restart_at,
                          input string tn);
    logic [7:0]  qb[$];
    logic [9:0]  qa[$];
    logic [7:0]  a;
    logic [31:0] wd;
    logic        rdy;
    logic        pv, pr;
    logic [7:0]  pbyte;
    logic [9:0]  pbadr;
    int          words, k, xfers, stall, limit;
    bit          stalled, restarted;

    words = int'(8'(la - fa)) + 1;
    for (int w = 0; w < words; w++) begin
      a  = 8'(int'(fa) + w);
      wd = rom1[a];
      for (int j = 0; j < NB; j++) begin
        k = msb ? (NB - 1 - j) : j;
        qb.push_back(8'(wd >> (8 * k)));
        qa.push_back(10'(int'(a) * NB + k));
      end
    end

    first_adr = fa; last_adr = la; msb_first = msb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    first_adr = 8'($urandom); last_adr = 8'($urandom); msb_first = ~msb;
    check({tn, " busy after start"}, 64'(busy), 64'(1));

    xfers = 0; stall = 0; stalled = 0; restarted = 0;
    pv = 0; pr = 0; pbyte = '0; pbadr = '0;
    limit = words * (2 + NB) * 6 + 50;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      if (mode == 1 && !stalled && s1.out_valid && xfers == 5) begin
        stalled = 1; stall = 3;
      end
      if (stall > 0) begin
        rdy = 1'b0; stall--;
      end else begin
        rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      s1.out_ready = rdy;

      if (s1.out_valid && pv && !pr) begin
        check({tn, " stall byte"}, 64'(s1.out_byte), 64'(pbyte));
        check({tn, " stall badr"}, 64'(s1.out_badr), 64'(pbadr));
      end
      if (s1.out_valid && rdy) begin
        check({tn, " byte left"}, 64'(qb.size() > 0), 64'(1));
        if (qb.size() > 0) begin
          check({tn, " byte"}, 64'(s1.out_byte), 64'(qb[0]));
          check({tn, " badr"}, 64'(s1.out_badr), 64'(qa[0]));
          void'(qb.pop_front());
          void'(qa.pop_front());
        end
        xfers++;
      end

      if (abort_after >= 0 && s1.out_valid && rdy && xfers == abort_after) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check({tn, " valid after abort"}, 64'(s1.out_valid), 64'(0));
        check({tn, " busy after abort"}, 64'(busy), 64'(0));
        for (int i = 0; i < 4; i++) begin
          check({tn, " no done after abort"}, 64'(done), 64'(0));
          @(negedge clk);
        end
        return;
      end

      if (restart_at >= 0 && !restarted && s1.out_valid && xfers == restart_at) begin
        start = 1'b1; restarted = 1;
        first_adr = 8'($urandom);
      end else begin
        start = 1'b0;
      end

      if (done) begin
        if (mode == 0) check({tn, " done cycle"}, 64'(cyc), 64'(words * (2 + NB) + 1));
        check({tn, " busy in done"}, 64'(busy), 64'(0));
        check({tn, " bytes remaining"}, 64'(qb.size()), 64'(0));
        check({tn, " valid in done"}, 64'(s1.out_valid), 64'(0));
        @(negedge clk);
        start = 1'b0;
        check({tn, " done one cycle"}, 64'(done), 64'(0));
        check({tn, " idle busy"}, 64'(busy), 64'(0));
        check({tn, " idle valid"}, 64'(s1.out_valid), 64'(0));
        return;
      end
      check({tn, " busy while running"}, 64'(busy), 64'(1));

      pv = s1.out_valid; pr = rdy; pbyte = s1.out_byte; pbadr = s1.out_badr;
      @(negedge clk);
    end
    check({tn, " timeout waiting for done"}, 64'(done), 64'(1));
  endtask

  initial begin
    logic [7:0] a;
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      rom1[i] = {a ^ 8'hFF, 8'(a + 8'd2), 8'(a + 8'd1), a};
      rom2[i] = {~a, a};
    end
    s1.out_ready = 1'b1;
    s2.out_ready = 1'b1;

    // reset, with start held high throughout
    rst = 1'b1; rst2 = 1'b1; start = 1'b1;
    repeat (2) @(negedge clk);
    check("rst rom_adr", 64'(rom_adr), 64'(0));
    check("rst valid", 64'(s1.out_valid), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    check("rst done", 64'(done), 64'(0));
    check("rst byte", 64'(s1.out_byte), 64'(0));
    check("rst badr", 64'(s1.out_badr), 64'(0));
    check("rst2 valid", 64'(s2.out_valid), 64'(0));
    rst = 1'b0; rst2 = 1'b0; start = 1'b0;
    @(negedge clk);
    check("start during reset ignored", 64'(busy), 64'(0));
    @(negedge clk);

    // T1 / T2 single word, both byte orders
    rom1[5] = 32'h44332211;
    run_dump(8'd5, 8'd5, 1'b0, 0, -1, -1, "T1");
    run_dump(8'd5, 8'd5, 1'b1, 0, -1, -1, "T2");

    // T3 full range
    rom1[5] = {8'h05 ^ 8'hFF, 8'h07, 8'h06, 8'h05};
    run_dump(8'd0, 8'd255, 1'b0, 0, -1, -1, "T3");

    // T4 wrap across the top with random backpressure
    for (int i = 0; i < 256; i++) rom1[i] = $urandom;
    run_dump(8'd254, 8'd1, 1'b0, 1, -1, -1, "T4");

    // T5 start ignored while busy, abort, then a clean dump
    run_dump(8'd10, 8'd12, 1'b1, 0, -1, 1, "T5 ignore");
    run_dump(8'd20, 8'd30, 1'b0, 0, 2, -1, "T5 abort");
    run_dump(8'd40, 8'd41, 1'b0, 1, -1, -1, "T5 again");

    // T6 two-cycle ROM latency, 16-bit words, async reset mid-EMIT
    fa2 = 8'd3; la2 = 8'd4; msb2 = 1'b0;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("T6 busy", 64'(busy2), 64'(1));
    for (int c = 1; c <= 3; c++) begin
      check("T6 fetch valid low", 64'(s2.out_valid), 64'(0));
      @(negedge clk);
    end
    check("T6 first valid", 64'(s2.out_valid), 64'(1));
    check("T6 byte0", 64'(s2.out_byte), 64'(8'h03));
    check("T6 badr0", 64'(s2.out_badr), 64'(6));
    @(negedge clk);
    check("T6 byte1", 64'(s2.out_byte), 64'(8'hFC));
    check("T6 badr1", 64'(s2.out_badr), 64'(7));
    @(negedge clk);
    check("T6 refetch valid low", 64'(s2.out_valid), 64'(0));
    repeat (3) @(negedge clk);
    check("T6 word2 valid", 64'(s2.out_valid), 64'(1));
    check("T6 word2 byte", 64'(s2.out_byte), 64'(8'h04));
    check("T6 word2 badr", 64'(s2.out_badr), 64'(8));
    check("T6 word2 rom_adr", 64'(rom_adr2), 64'(4));
    #1 rst2 = 1'b1;
    #1;
    check("T6 async valid", 64'(s2.out_valid), 64'(0));
    check("T6 async busy", 64'(busy2), 64'(0));
    check("T6 async rom_adr", 64'(rom_adr2), 64'(0));
    check("T6 async byte", 64'(s2.out_byte), 64'(0));
    @(negedge clk);
    rst2 = 1'b0;
    @(negedge clk);
    check("T6 post reset busy", 64'(busy2), 64'(0));
    check("T6 post reset done", 64'(done2), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
